clk_div_bank: RTL

Multi-channel, runtime-programmable clock divider and tick generator. It replaces fixed single-divisor dividers in the memory/peripheral subsystem, for example the CPU-side /2 clock and the UART /868 baud rate. Each channel produces a divided level and a one-cycle enable tick from i_clk. Each channel's divisor can be reprogrammed over a valid/ready port, and the new value takes effect glitch-free at the channel's next period boundary.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_chan.sv | 120 ++++++++++++
 rtl/clk_div_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clk_div_bank divider slice.
//   ch_state_e      per-channel FSM state (IDLE / RUN / RUN_PEND)
//   MIN_DIV         smallest divisor a channel accepts
//   DIV_CPU         default divisor for the CPU-side /2 clock
//   DIV_UART_115200 default divisor for the UART baud tick
//   high_len()      length of the high phase for a divisor d: ceil(d/2)
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } ch_state_e;

  localparam int MIN_DIV         = 2;
  localparam int DIV_CPU         = 2;
  localparam int DIV_UART_115200 = 868;

  // Odd divisors spend the extra cycle in the high phase.
  function automatic logic [31:0] high_len(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (counter, FSM, active/shadow divisor).
// Ports:
//   i_clk, i_rst_n_sync  clock, asynchronous active-low reset
//   i_started            low only during the first cycle after reset release;
//                        the counter does not advance while it is low
//   i_en                 run enable; low forces IDLE (cnt=0, level high)
//   i_wr, i_wr_div       write the shadow divisor and mark it pending
//   o_pend               a shadow divisor is waiting for the next boundary
//   o_clk_div            registered divided level (high while cnt < ceil(D/2))
//   o_tick               registered strobe on the last cycle of each period
//   o_state              current FSM state, for debug and checkers
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int              CNT_W   = 16,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DIV_CPU)
) (
  input  logic             i_clk,
  input  logic             i_rst_n_sync,
  input  logic             i_started,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_pend,
  output logic             o_clk_div,
  output logic             o_tick,
  output ch_state_e        o_state
);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_act, act_nxt;
  logic [CNT_W-1:0] div_shadow, shadow_nxt;
  logic             pend, pend_nxt;
  logic             clk_q, clk_nxt;
  logic             tick_q, tick_nxt;

  // State register (also holds the datapath and the registered outputs).
  always_ff @(posedge i_clk or negedge i_rst_n_sync) begin
    if (!i_rst_n_sync) begin
      state      <= IDLE;
      cnt        <= '0;
      div_act    <= DEF_DIV;
      div_shadow <= DEF_DIV;
      pend       <= 1'b0;
      clk_q      <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      div_act    <= act_nxt;
      div_shadow <= shadow_nxt;
      pend       <= pend_nxt;
      clk_q      <= clk_nxt;
      tick_q     <= tick_nxt;
    end
  end

  // Next-state logic. A pending divisor is only swapped in at a period
  // boundary: the wrap from D-1 to 0, or any cycle spent in IDLE.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    act_nxt    = div_act;
    shadow_nxt = div_shadow;
    pend_nxt   = pend;
    if (!i_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      if (pend) begin
        act_nxt  = div_shadow;
        pend_nxt = 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          if (pend) begin
            act_nxt  = div_shadow;
            pend_nxt = 1'b0;
          end
        end
        RUN, RUN_PEND: begin
          if (i_started) begin
            if (cnt == div_act - 1'b1) begin
              cnt_nxt = '0;
              if (pend) begin
                act_nxt   = div_shadow;
                pend_nxt  = 1'b0;
                state_nxt = RUN;
              end
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // Writes only arrive while pend is low, so they never collide with a swap.
    if (i_wr) begin
      shadow_nxt = i_wr_div;
      pend_nxt   = 1'b1;
      if (state_nxt != IDLE) state_nxt = RUN_PEND;
    end
  end

  // Output logic, evaluated on the next values so the outputs are registered.
  always_comb begin
    clk_nxt  = (32'(cnt_nxt) < high_len(32'(act_nxt)));
    tick_nxt = (state_nxt != IDLE) && (cnt_nxt == act_nxt - 1'b1);
  end

  assign o_pend    = pend;
  assign o_clk_div = clk_q;
  assign o_tick    = tick_q;
  assign o_state   = state;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH runtime-programmable clock dividers / tick generators.
// Optional feature macro: CLKDIV_TICK_EN (adds the o_tick port).
// Ports:
//   i_clk, i_rst_n_sync  clock, asynchronous active-low reset
//   i_en                 per-channel run enable
//   i_cfg_valid/o_cfg_ready, i_cfg_ch, i_cfg_div   divisor update port
//   o_cfg_err            one-cycle pulse after a rejected update
//   o_clk_div            per-channel divided level (logic signal)
//   o_tick               per-channel one-cycle strobe per period
// Config handshake: an update transfers on a cycle where i_cfg_valid and
// o_cfg_ready are both high. o_cfg_ready is low while the addressed channel
// still holds an unapplied divisor, and is always high for an out-of-range
// channel so that a bad request is consumed and reported via o_cfg_err.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                       NUM_CH      = 2,
  parameter int                       CNT_W       = 16,
  parameter logic [NUM_CH*CNT_W-1:0]  DEFAULT_DIV = {CNT_W'(DIV_UART_115200), CNT_W'(DIV_CPU)},
  localparam int                      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n_sync,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_div,
  output logic              o_cfg_err,
  output logic [NUM_CH-1:0] o_clk_div
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NUM_CH-1:0] o_tick
`endif
);

  logic              started;
  logic [31:0]       ch_ext;
  logic              ch_ok;
  logic              div_ok;
  logic              sel_pend;
  logic              accept;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] tick_int;
  ch_state_e         unused_dbg_state [NUM_CH];

  // Shared start hold: clears with reset, sets on the first clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n_sync) begin
    if (!i_rst_n_sync) started <= 1'b0;
    else               started <= 1'b1;
  end

  assign ch_ext = 32'(i_cfg_ch);
  assign ch_ok  = (ch_ext < 32'(NUM_CH));
  assign div_ok = (i_cfg_div >= CNT_W'(MIN_DIV));

  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_ext == 32'(i)) sel_pend = pend[i];
    end
  end

  assign o_cfg_ready = ch_ok ? ~sel_pend : 1'b1;
  assign accept      = i_cfg_valid & o_cfg_ready;

  always_ff @(posedge i_clk or negedge i_rst_n_sync) begin
    if (!i_rst_n_sync) o_cfg_err <= 1'b0;
    else               o_cfg_err <= accept & (~ch_ok | ~div_ok);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr;
    assign wr = accept & div_ok & (ch_ext == 32'(g));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEFAULT_DIV[g*CNT_W +: CNT_W])
    ) u_chan (
      .i_clk        (i_clk),
      .i_rst_n_sync (i_rst_n_sync),
      .i_started    (started),
      .i_en         (i_en[g]),
      .i_wr         (wr),
      .i_wr_div     (i_cfg_div),
      .o_pend       (pend[g]),
      .o_clk_div    (o_clk_div[g]),
      .o_tick       (tick_int[g]),
      .o_state      (unused_dbg_state[g])
    );
  end

`ifdef CLKDIV_TICK_EN
  assign o_tick = tick_int;
`else
  logic [NUM_CH-1:0] unused_tick;
  assign unused_tick = tick_int;
`endif

endmodule
